// File: rtl/tdm_demux8_pkg.sv
// tdm_demux8_pkg: shared slot geometry and lock-state codes for the TDM link.
// The transmit-side serializer imports the same package.
package tdm_demux8_pkg;
    localparam int TDM_SLOTS  = 8;
    localparam int TDM_SLOT_W = 3;
    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } tdm_state_t;
endpackage

// File: rtl/tdm_sync_fsm.sv
// tdm_sync_fsm: HUNT/LOCK tracking, slot counter and missed-marker counting.
// Tells the datapath where each valid bit goes and when a frame completes.
module tdm_sync_fsm
    import tdm_demux8_pkg::*;
#(
    parameter int SYNC_LOSS_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [TDM_SLOT_W-1:0] slot,
    output logic                  wr_en,
    output logic                  frame_done,
    output logic                  realign,
    output logic                  locked,
    output logic                  sync_err
);
    localparam logic [2:0] LIMIT = 3'(SYNC_LOSS_LIMIT);

    tdm_state_t            state, state_n;
    logic [TDM_SLOT_W-1:0] slot_n;
    logic [2:0]            miss, miss_n, miss_inc;
    logic                  err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HUNT;
            slot     <= '0;
            miss     <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_n;
            slot     <= slot_n;
            miss     <= miss_n;
            sync_err <= err_n;
        end
    end

    // A marker always restarts the frame at slot 0; outside slot 0 while locked it is an error.
    always_comb begin
        state_n    = state;
        slot_n     = slot;
        miss_n     = miss;
        err_n      = 1'b0;
        wr_en      = 1'b0;
        realign    = 1'b0;
        frame_done = 1'b0;
        miss_inc   = miss + 3'd1;
        if (din_valid) begin
            if (frame_sync) begin
                state_n = ST_LOCK;
                wr_en   = 1'b1;
                realign = 1'b1;
                slot_n  = 3'd1;
                miss_n  = '0;
                err_n   = (state == ST_LOCK) && (slot != '0);
            end else if (state == ST_LOCK) begin
                if (slot == '0 && miss_inc == LIMIT) begin
                    state_n = ST_HUNT;
                    miss_n  = miss_inc;
                end else begin
                    wr_en      = 1'b1;
                    slot_n     = slot + 3'd1;
                    miss_n     = (slot == '0) ? miss_inc : miss;
                    frame_done = (slot == 3'(TDM_SLOTS - 1));
                end
            end
        end
    end

    assign locked = (state == ST_LOCK);
endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive side of the 8:1 TDM link; rebuilds 8-bit frames from the
// serial stream and exposes one selected channel.
module tdm_demux8
    import tdm_demux8_pkg::*;
#(
    parameter int SYNC_LOSS_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    input  logic [TDM_SLOT_W-1:0] ch_sel,
    output logic [TDM_SLOTS-1:0]  dout,
    output logic                  frame_valid,
    output logic                  ch_out,
    output logic                  locked,
    output logic                  sync_err
);
    logic [TDM_SLOT_W-1:0] slot;
    logic                  wr_en, frame_done, realign;
    logic [TDM_SLOTS-1:0]  slot_buf;

    tdm_sync_fsm #(.SYNC_LOSS_LIMIT(SYNC_LOSS_LIMIT)) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .slot       (slot),
        .wr_en      (wr_en),
        .frame_done (frame_done),
        .realign    (realign),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    // The slot-7 bit bypasses the buffer so dout appears on the sampling edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_buf    <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (wr_en)
                slot_buf[realign ? '0 : slot] <= din;
            if (frame_done)
                dout <= {din, slot_buf[TDM_SLOTS-2:0]};
        end
    end

    assign ch_out = dout[ch_sel];
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: table-driven check of tdm_demux8 framing, lock loss, misalignment
// and async reset, with hand-computed expected outputs.
module tb_tdm_demux8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [2:0] ch_sel = 3'd0;
    logic [7:0] dout;
    logic       frame_valid, ch_out, locked, sync_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       din, dv, fs;
        logic [2:0] sel;
        logic [7:0] e_dout;
        logic       e_fv, e_lk, e_err, e_co;
    } vec_t;

    vec_t vq[$];
    int   rst_idx;

    tdm_demux8 #(.SYNC_LOSS_LIMIT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_sel      (ch_sel),
        .dout        (dout),
        .frame_valid (frame_valid),
        .ch_out      (ch_out),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic v(input logic d, dv, fs, input logic [2:0] sel, input logic [7:0] ed,
                     input logic fv, lk, err);
        vec_t e;
        e.din = d; e.dv = dv; e.fs = fs; e.sel = sel;
        e.e_dout = ed; e.e_fv = fv; e.e_lk = lk; e.e_err = err; e.e_co = ed[sel];
        vq.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] ed, input logic fv, lk, err, co);
        tests++;
        if ({dout, frame_valid, locked, sync_err, ch_out} !== {ed, fv, lk, err, co}) begin
            fails++;
            $display("FAIL %s: got dout=%h fv=%b lk=%b err=%b co=%b, want dout=%h fv=%b lk=%b err=%b co=%b",
                     name, dout, frame_valid, locked, sync_err, ch_out, ed, fv, lk, err, co);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            din = vq[i].din; din_valid = vq[i].dv; frame_sync = vq[i].fs; ch_sel = vq[i].sel;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vq[i].e_dout, vq[i].e_fv, vq[i].e_lk, vq[i].e_err, vq[i].e_co);
        end
    endtask

    initial begin
        // T1: marker frame 1,0,1,1,0,0,1,0 -> 4D
        v(1,1,1,0,8'h00,0,1,0); v(0,1,0,0,8'h00,0,1,0); v(1,1,0,0,8'h00,0,1,0); v(1,1,0,0,8'h00,0,1,0);
        v(0,1,0,0,8'h00,0,1,0); v(0,1,0,0,8'h00,0,1,0); v(1,1,0,0,8'h00,0,1,0); v(0,1,0,0,8'h4D,1,1,0);
        v(0,0,0,0,8'h4D,0,1,0);
        // T2: same frame with a 3-cycle valid gap between slots 3 and 4
        v(1,1,1,0,8'h4D,0,1,0); v(0,1,0,0,8'h4D,0,1,0); v(1,1,0,0,8'h4D,0,1,0); v(1,1,0,0,8'h4D,0,1,0);
        for (int i = 0; i < 3; i++) v(1,0,1,0,8'h4D,0,1,0);
        v(0,1,0,0,8'h4D,0,1,0); v(0,1,0,0,8'h4D,0,1,0); v(1,1,0,0,8'h4D,0,1,0); v(0,1,0,0,8'h4D,1,1,0);
        v(0,0,0,0,8'h4D,0,1,0);
        // T3: marker at slot 5 realigns; following 7 bits complete A5
        v(0,1,1,0,8'h4D,0,1,0);
        for (int i = 0; i < 4; i++) v(1,1,0,0,8'h4D,0,1,0);
        v(1,1,1,0,8'h4D,0,1,1);
        v(0,1,0,0,8'h4D,0,1,0); v(1,1,0,0,8'h4D,0,1,0); v(0,1,0,0,8'h4D,0,1,0); v(0,1,0,0,8'h4D,0,1,0);
        v(1,1,0,0,8'h4D,0,1,0); v(0,1,0,0,8'h4D,0,1,0); v(1,1,0,0,8'hA5,1,1,0);
        // T6: ch_sel sweep over A5
        for (int k = 0; k < 8; k++) v(0,0,0,3'(k),8'hA5,0,1,0);
        // T4: one unmarked frame (3C) still output, second unmarked slot 0 drops lock
        v(0,1,0,0,8'hA5,0,1,0); v(0,1,0,0,8'hA5,0,1,0); v(1,1,0,0,8'hA5,0,1,0); v(1,1,0,0,8'hA5,0,1,0);
        v(1,1,0,0,8'hA5,0,1,0); v(1,1,0,0,8'hA5,0,1,0); v(0,1,0,0,8'hA5,0,1,0); v(0,1,0,0,8'h3C,1,1,0);
        v(1,1,0,0,8'h3C,0,0,0);
        for (int i = 0; i < 8; i++) v(1,1,0,0,8'h3C,0,0,0);
        // marker at slot 7 is a misalignment, not a frame
        v(1,1,1,0,8'h3C,0,1,0);
        for (int i = 0; i < 6; i++) v(1,1,0,0,8'h3C,0,1,0);
        v(1,1,1,0,8'h3C,0,1,1);
        v(0,0,0,0,8'h3C,0,1,0);
        v(0,1,0,0,8'h3C,0,1,0); v(0,1,0,0,8'h3C,0,1,0); v(0,1,0,0,8'h3C,0,1,0);
        rst_idx = vq.size();
        // T5 tail: after reset, unmarked data is ignored; a marked frame 81 then locks
        for (int i = 0; i < 8; i++) v(1,1,0,0,8'h00,0,0,0);
        v(1,1,1,0,8'h00,0,1,0);
        for (int i = 0; i < 6; i++) v(0,1,0,0,8'h00,0,1,0);
        v(1,1,0,0,8'h81,1,1,0);
        v(0,0,0,3'd7,8'h81,0,1,0);

        repeat (2) @(negedge clk);
        check("reset_state", 8'h00, 0, 0, 0, 0);
        rst_n = 1'b1;
        run(0, rst_idx);
        // T5: async reset while slot 4 is being presented
        @(negedge clk);
        din = 1'b1; din_valid = 1'b1; frame_sync = 1'b0; ch_sel = 3'd2;
        #2 rst_n = 1'b0;
        #1 check("async_reset", 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #1 check("reset_hold", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(rst_idx, vq.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
